controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 The block SHALL have these ports, in order:
  clock  in  1  single clock; all state changes on its rising edge
  reset  in  1  asynchronous, active-high reset
  OPcode  in  6  IR[31:26]
  funct  in  6  IR[5:0]
  EscreveMem, EscreveAluOut, EscrevePC, EscreveMDR, EscrevePCCondEQ, EscrevePCCondNE, EscreveReg, EscreveIR  out  1 each  write/load enables
  IouD  out  1  memory address: 0=PC, 1=AluOut
  RegDst  out  1  write register: 0=rt, 1=rd
  OrigAALU  out  1  ALU A: 0=PC, 1=A
  OrigBALU  out  2  ALU B: 00=B, 01=4, 10=signext, 11=signext<<2
  OrigPC  out  2  PC source: 00=ALU, 01=AluOut, 10=jump target
  MemparaReg  out  2  register write data: 00=AluOut, 01=MDR, 10=LUI
  OpALU  out  3  000=add, 001=sub, 010=decode funct
  State  out  6  current state code

Function
REQ-002 The block SHALL be a Moore FSM; all outputs SHALL be a function of the current state only; every output not listed for a state SHALL be 0.
REQ-003 State codes and outputs SHALL be:
  0 RST: all 0
  1 FETCH: OrigBALU=01
  2 FETCH_WAIT: as FETCH
  3 FETCH_LD: OrigBALU=01, EscreveIR=1, EscrevePC=1
  4 DECODE: OrigBALU=11, EscreveAluOut=1
  5 MEM_ADDR: OrigAALU=1, OrigBALU=10, EscreveAluOut=1
  6 LW_RD: IouD=1
  7 LW_WAIT: IouD=1
  8 LW_LD: IouD=1, EscreveMDR=1
  9 LW_WB: MemparaReg=01, EscreveReg=1
  10 SW_WR: IouD=1, EscreveMem=1
  11 R_EXEC: OrigAALU=1, OpALU=010, EscreveAluOut=1
  12 R_WB: RegDst=1, EscreveReg=1
  13 BRANCH: OrigAALU=1, OpALU=001, OrigPC=01, EscrevePCCondEQ=1 (beq) or EscrevePCCondNE=1 (bne)
  14 JUMP: OrigPC=10, EscrevePC=1
  15 LUI_WB: MemparaReg=10, EscreveReg=1
  16 ADDI_EXEC: OrigAALU=1, OrigBALU=10, EscreveAluOut=1
  17 ADDI_WB: EscreveReg=1
  63 ILLEGAL: all 0
REQ-004 Transitions SHALL be: RST->FETCH; FETCH->FETCH_WAIT (macro on) or FETCH_LD (macro off); FETCH_WAIT->FETCH_LD; FETCH_LD->DECODE.
REQ-005 DECODE SHALL dispatch on OPcode: 0x00->R_EXEC; 0x23 and 0x2B->MEM_ADDR; 0x04 and 0x05->BRANCH; 0x02->JUMP; 0x0F->LUI_WB; 0x08->ADDI_EXEC; any other value->ILLEGAL.
REQ-006 OPcode 0x00 with funct not in {0x20, 0x22, 0x24} SHALL go to ILLEGAL.
REQ-007 MEM_ADDR SHALL go to LW_RD for 0x23 and to SW_WR for 0x2B; LW_RD->LW_WAIT (macro on) or LW_LD (macro off); LW_WAIT->LW_LD; LW_LD->LW_WB.
REQ-008 R_EXEC->R_WB; ADDI_EXEC->ADDI_WB; LW_WB, R_WB, SW_WR, BRANCH, JUMP, LUI_WB, ADDI_WB and ILLEGAL SHALL each go to FETCH.
REQ-009 BRANCH SHALL assert exactly one of EscrevePCCondEQ/EscrevePCCondNE, selected by OPcode[0] (0=EQ, 1=NE).
REQ-010 The OPcode held in IR SHALL remain stable from FETCH_LD until the next FETCH_LD; the FSM SHALL sample OPcode/funct only in DECODE, MEM_ADDR and BRANCH.
REQ-011 Exactly one state SHALL be active per cycle; unreachable codes SHALL go to ILLEGAL.

Reset
REQ-012 While reset=1, State SHALL be 0 and every output SHALL be 0 immediately, without waiting for a clock edge, including mid-instruction (e.g. during SW_WR, EscreveMem drops at once).
REQ-013 The first rising edge after reset deasserts SHALL move the FSM to FETCH.

Configuration
REQ-014 Macro MEM_WAIT_EN: defined -> FETCH_WAIT and LW_WAIT are traversed (fetch = 3 cycles, lw = 9 cycles total); undefined -> they are never entered (fetch = 2, lw = 7); the state codes SHALL be identical in both builds.

Verification
REQ-015 Reset, then release; macro off: State sequence 0,1,3,4 on successive edges; EscreveIR=EscrevePC=1 only while State=3.
REQ-016 add (OPcode 0x00, funct 0x20): State 1,3,4,11,12,1; OpALU=010 in state 11; RegDst=1, EscreveReg=1 only in state 12; 5 cycles.
REQ-017 lw (0x23) with MEM_WAIT_EN: 1,2,3,4,5,6,7,8,9,1; EscreveMDR=1 only in state 8; IouD=1 in states 6-8.
REQ-018 bne (0x05): State 13 with OpALU=001, OrigPC=01, EscrevePCCondNE=1, EscrevePCCondEQ=0; beq (0x04) swaps the two.
REQ-019 OPcode 0x3F -> DECODE->63->1, no enable asserted; OPcode 0x00/funct 0x08 -> 63.
REQ-020 Reset asserted asynchronously mid SW_WR (State=10): EscreveMem=0 and State=0 before the next edge; after release, resume at FETCH.

Source files
------------

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for a multi-cycle MIPS-like datapath.
// Decodes OPcode/funct into per-state write enables and mux selects.
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   OPcode, funct           - IR[31:26] and IR[5:0]
//   Escreve*                - memory/register/PC/IR write enables
//   IouD, RegDst, OrigAALU  - address, destination register and ALU A selects
//   OrigBALU, OrigPC        - ALU B and PC source selects
//   MemparaReg, OpALU       - register write-data select and ALU operation
//   State                   - current state code
// Build option: define MEM_WAIT_EN to insert one memory wait state in the
// instruction fetch (FETCH_WAIT) and in the load path (LW_WAIT).
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPcode,
  input  logic [5:0] funct,
  output logic       EscreveMem,
  output logic       EscreveAluOut,
  output logic       EscrevePC,
  output logic       EscreveMDR,
  output logic       EscrevePCCondEQ,
  output logic       EscrevePCCondNE,
  output logic       EscreveReg,
  output logic       EscreveIR,
  output logic       IouD,
  output logic       RegDst,
  output logic       OrigAALU,
  output logic [1:0] OrigBALU,
  output logic [1:0] OrigPC,
  output logic [1:0] MemparaReg,
  output logic [2:0] OpALU,
  output logic [5:0] State
);

  localparam int unsigned STATE_W = 6;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;

  typedef enum logic [STATE_W-1:0] {
    S_RST        = 6'd0,
    S_FETCH      = 6'd1,
    S_FETCH_WAIT = 6'd2,
    S_FETCH_LD   = 6'd3,
    S_DECODE     = 6'd4,
    S_MEM_ADDR   = 6'd5,
    S_LW_RD      = 6'd6,
    S_LW_WAIT    = 6'd7,
    S_LW_LD      = 6'd8,
    S_LW_WB      = 6'd9,
    S_SW_WR      = 6'd10,
    S_R_EXEC     = 6'd11,
    S_R_WB       = 6'd12,
    S_BRANCH     = 6'd13,
    S_JUMP       = 6'd14,
    S_LUI_WB     = 6'd15,
    S_ADDI_EXEC  = 6'd16,
    S_ADDI_WB    = 6'd17,
    S_ILLEGAL    = 6'd63
  } state_t;

  typedef struct packed {
    logic       mem_we;
    logic       aluout_we;
    logic       pc_we;
    logic       mdr_we;
    logic       pc_eq_we;
    logic       pc_ne_we;
    logic       reg_we;
    logic       ir_we;
    logic       iord;
    logic       reg_dst;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q,  ctrl_d;

  // Control word for a given state; branch polarity comes from OPcode[0].
  function automatic ctrl_t ctrl_for(input state_t s, input logic is_bne);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH, S_FETCH_WAIT: c.alu_b = 2'b01;
      S_FETCH_LD: begin
        c.alu_b = 2'b01;
        c.ir_we = 1'b1;
        c.pc_we = 1'b1;
      end
      S_DECODE: begin
        c.alu_b     = 2'b11;
        c.aluout_we = 1'b1;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        c.alu_a     = 1'b1;
        c.alu_b     = 2'b10;
        c.aluout_we = 1'b1;
      end
      S_LW_RD, S_LW_WAIT: c.iord = 1'b1;
      S_LW_LD: begin
        c.iord   = 1'b1;
        c.mdr_we = 1'b1;
      end
      S_LW_WB: begin
        c.mem_to_reg = 2'b01;
        c.reg_we     = 1'b1;
      end
      S_SW_WR: begin
        c.iord   = 1'b1;
        c.mem_we = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_a     = 1'b1;
        c.alu_op    = 3'b010;
        c.aluout_we = 1'b1;
      end
      S_R_WB: begin
        c.reg_dst = 1'b1;
        c.reg_we  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_a    = 1'b1;
        c.alu_op   = 3'b001;
        c.pc_src   = 2'b01;
        c.pc_eq_we = ~is_bne;
        c.pc_ne_we = is_bne;
      end
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.pc_we  = 1'b1;
      end
      S_LUI_WB: begin
        c.mem_to_reg = 2'b10;
        c.reg_we     = 1'b1;
      end
      S_ADDI_WB: c.reg_we = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state plus the control word that will be registered with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_FETCH;
`ifdef MEM_WAIT_EN
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_FETCH_LD;
`else
      S_FETCH:      state_d = S_FETCH_LD;
      S_FETCH_WAIT: state_d = S_ILLEGAL;
`endif
      S_FETCH_LD: state_d = S_DECODE;
      S_DECODE: begin
        case (OPcode)
          OP_RTYPE: begin
            if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND)) begin
              state_d = S_R_EXEC;
            end else begin
              state_d = S_ILLEGAL;
            end
          end
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_LUI:         state_d = S_LUI_WB;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (OPcode == OP_SW) ? S_SW_WR : S_LW_RD;
`ifdef MEM_WAIT_EN
      S_LW_RD:   state_d = S_LW_WAIT;
      S_LW_WAIT: state_d = S_LW_LD;
`else
      S_LW_RD:   state_d = S_LW_LD;
      S_LW_WAIT: state_d = S_ILLEGAL;
`endif
      S_LW_LD:     state_d = S_LW_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_LW_WB, S_R_WB, S_SW_WR, S_BRANCH, S_JUMP, S_LUI_WB, S_ADDI_WB, S_ILLEGAL:
        state_d = S_FETCH;
      default: state_d = S_ILLEGAL;
    endcase
    ctrl_d = ctrl_for(state_d, OPcode[0]);
  end

  // State and control word share the async reset, so outputs clear immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign EscreveMem      = ctrl_q.mem_we;
  assign EscreveAluOut   = ctrl_q.aluout_we;
  assign EscrevePC       = ctrl_q.pc_we;
  assign EscreveMDR      = ctrl_q.mdr_we;
  assign EscrevePCCondEQ = ctrl_q.pc_eq_we;
  assign EscrevePCCondNE = ctrl_q.pc_ne_we;
  assign EscreveReg      = ctrl_q.reg_we;
  assign EscreveIR       = ctrl_q.ir_we;
  assign IouD            = ctrl_q.iord;
  assign RegDst          = ctrl_q.reg_dst;
  assign OrigAALU        = ctrl_q.alu_a;
  assign OrigBALU        = ctrl_q.alu_b;
  assign OrigPC          = ctrl_q.pc_src;
  assign MemparaReg      = ctrl_q.mem_to_reg;
  assign OpALU           = ctrl_q.alu_op;
  assign State           = STATE_W'(state_q);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Testbench for controle_multiciclo: table-driven instruction sequences with
// per-cycle state and control-word checks, plus reset corner cases.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OPcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       EscreveMem, EscreveAluOut, EscrevePC, EscreveMDR;
  logic       EscrevePCCondEQ, EscrevePCCondNE, EscreveReg, EscreveIR;
  logic       IouD, RegDst, OrigAALU;
  logic [1:0] OrigBALU, OrigPC, MemparaReg;
  logic [2:0] OpALU;
  logic [5:0] State;

  controle_multiciclo dut (
    .clock(clock), .reset(reset), .OPcode(OPcode), .funct(funct),
    .EscreveMem(EscreveMem), .EscreveAluOut(EscreveAluOut), .EscrevePC(EscrevePC),
    .EscreveMDR(EscreveMDR), .EscrevePCCondEQ(EscrevePCCondEQ),
    .EscrevePCCondNE(EscrevePCCondNE), .EscreveReg(EscreveReg), .EscreveIR(EscreveIR),
    .IouD(IouD), .RegDst(RegDst), .OrigAALU(OrigAALU), .OrigBALU(OrigBALU),
    .OrigPC(OrigPC), .MemparaReg(MemparaReg), .OpALU(OpALU), .State(State)
  );

  always #5 clock = ~clock;

  logic [19:0] act;
  assign act = {EscreveMem, EscreveAluOut, EscrevePC, EscreveMDR, EscrevePCCondEQ,
                EscrevePCCondNE, EscreveReg, EscreveIR, IouD, RegDst, OrigAALU,
                OrigBALU, OrigPC, MemparaReg, OpALU};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    int         tail [5];
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];

  // Expected control word per state, written straight from the state table.
  function automatic logic [19:0] model(input int s, input logic [5:0] op);
    logic mem, alu, pc, mdr, eq, ne, wreg, ir, iord, rdst, a;
    logic [1:0] b, pcs, m2r;
    logic [2:0] opa;
    {mem, alu, pc, mdr, eq, ne, wreg, ir, iord, rdst, a} = '0;
    b = 2'b00; pcs = 2'b00; m2r = 2'b00; opa = 3'b000;
    case (s)
      1, 2: b = 2'b01;
      3:  begin b = 2'b01; ir = 1'b1; pc = 1'b1; end
      4:  begin b = 2'b11; alu = 1'b1; end
      5:  begin a = 1'b1; b = 2'b10; alu = 1'b1; end
      6, 7: iord = 1'b1;
      8:  begin iord = 1'b1; mdr = 1'b1; end
      9:  begin m2r = 2'b01; wreg = 1'b1; end
      10: begin iord = 1'b1; mem = 1'b1; end
      11: begin a = 1'b1; opa = 3'b010; alu = 1'b1; end
      12: begin rdst = 1'b1; wreg = 1'b1; end
      13: begin a = 1'b1; opa = 3'b001; pcs = 2'b01; eq = ~op[0]; ne = op[0]; end
      14: begin pcs = 2'b10; pc = 1'b1; end
      15: begin m2r = 2'b10; wreg = 1'b1; end
      16: begin a = 1'b1; b = 2'b10; alu = 1'b1; end
      17: wreg = 1'b1;
      default: ;
    endcase
    return {mem, alu, pc, mdr, eq, ne, wreg, ir, iord, rdst, a, b, pcs, m2r, opa};
  endfunction

  task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input int n,
                         input int t0, input int t1, input int t2, input int t3,
                         input int t4);
    vec_t v;
    v.op = op; v.fn = fn; v.len = n;
    v.tail[0] = t0; v.tail[1] = t1; v.tail[2] = t2; v.tail[3] = t3; v.tail[4] = t4;
    vecs.push_back(v);
  endtask

  // Full state sequence from FETCH; wait states dropped when the option is off.
  task automatic build_exp(input vec_t v);
    int full[$];
    exp_q.delete();
    full = '{1, 2, 3, 4};
    for (int i = 0; i < v.len; i++) full.push_back(v.tail[i]);
    foreach (full[i]) begin
`ifdef MEM_WAIT_EN
      exp_q.push_back(full[i]);
`else
      if (full[i] != 2 && full[i] != 7) exp_q.push_back(full[i]);
`endif
    end
  endtask

  task automatic check_cycle(input int exp_s, input logic [5:0] op, input int tag);
    logic [19:0] e;
    e = model(exp_s, op);
    checks++;
    if (State != 6'(exp_s)) begin
      errors++;
      $display("FAIL state vec=%0d got=%0d expected=%0d", tag, State, exp_s);
    end
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL ctrl vec=%0d state=%0d got=%h expected=%h", tag, exp_s, act, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Table: opcode, funct, tail length, states after DECODE.
    add_vec(6'h00, 6'h20, 2, 11, 12, 0, 0, 0);   // add
    add_vec(6'h00, 6'h22, 2, 11, 12, 0, 0, 0);   // sub
    add_vec(6'h00, 6'h24, 2, 11, 12, 0, 0, 0);   // and
    add_vec(6'h23, 6'h00, 5, 5, 6, 7, 8, 9);     // lw
    add_vec(6'h2B, 6'h00, 2, 5, 10, 0, 0, 0);    // sw
    add_vec(6'h04, 6'h00, 1, 13, 0, 0, 0, 0);    // beq
    add_vec(6'h05, 6'h00, 1, 13, 0, 0, 0, 0);    // bne
    add_vec(6'h02, 6'h00, 1, 14, 0, 0, 0, 0);    // j
    add_vec(6'h0F, 6'h00, 1, 15, 0, 0, 0, 0);    // lui
    add_vec(6'h08, 6'h00, 2, 16, 17, 0, 0, 0);   // addi
    add_vec(6'h3F, 6'h00, 1, 63, 0, 0, 0, 0);    // unknown opcode
    add_vec(6'h00, 6'h08, 1, 63, 0, 0, 0, 0);    // R-type, unsupported funct

    // Held in reset: state 0, all outputs low, also across clock edges.
    #3;
    check_cycle(0, 6'h00, -1);
    repeat (2) @(posedge clock);
    #1;
    check_cycle(0, 6'h00, -1);
    @(negedge clock);
    reset = 1'b0;
    check_cycle(0, 6'h00, -1);
    step();

    foreach (vecs[k]) begin
      build_exp(vecs[k]);
      OPcode = vecs[k].op;
      funct  = vecs[k].fn;
      foreach (exp_q[i]) begin
        check_cycle(exp_q[i], vecs[k].op, k);
        step();
      end
      check_cycle(1, vecs[k].op, k);
    end

    // Async reset in the middle of a store: outputs drop before the next edge.
    OPcode = 6'h2B;
    funct  = 6'h00;
    begin
      vec_t v;
      v = vecs[4];
      v.len = 2;
      build_exp(v);
    end
    foreach (exp_q[i]) begin
      check_cycle(exp_q[i], 6'h2B, 100);
      if (exp_q[i] != 10) step();
    end
    reset = 1'b1;
    #1;
    check_cycle(0, 6'h2B, 101);
    @(negedge clock);
    reset = 1'b0;
    check_cycle(0, 6'h2B, 102);
    step();
    check_cycle(1, 6'h2B, 103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
